fpu_arbiter: RTL

Shares one pipelined FPU_unit (registered inputs, registered output, 2-cycle latency, one issue per cycle) among NUM_REQ independent requesters. Each cycle it arbitrates among valid requests, registers the winning operation onto the FPU issue port, and tags it with the requester ID. The tag travels in a shift register matched to the FPU latency and routes each result back to its owner. Sits between the core-side requesters and the FPU_unit instance.

---
 rtl/fpu_arb_pkg.sv | 17 +
 rtl/fpu_arbiter_if.sv | 31 +++
 rtl/fpu_arb_picker.sv | 44 ++++
 rtl/fpu_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared encodings and tag type for the FPU arbiter.
// ID_W covers the largest supported requester count (8).
package fpu_arb_pkg;

   localparam int FPU_LAT_DEF = 2;
   localparam int MAX_REQ     = 8;
   localparam int ID_W        = $clog2(MAX_REQ);

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester, FPU issue and response signals of the FPU arbiter.
// slave is the arbiter's view, master is the surrounding requesters/FPU.
interface fpu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int NUM_OP  = 1
);
   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic [NUM_REQ*NUM_OP-1:0] i_req_op;
   logic [NUM_REQ*32-1:0]     i_req_a;
   logic [NUM_REQ*32-1:0]     i_req_b;
   logic [NUM_OP-1:0]         o_fpu_alu_op;
   logic [31:0]               o_fpu_data_a;
   logic [31:0]               o_fpu_data_b;
   logic [31:0]               i_fpu_result;
   logic [NUM_REQ-1:0]        o_rsp_valid;
   logic [31:0]               o_rsp_data;
   logic                      o_busy;

   modport slave (
      input  i_req_valid, i_req_op, i_req_a, i_req_b, i_fpu_result,
      output o_req_ready, o_fpu_alu_op, o_fpu_data_a, o_fpu_data_b,
             o_rsp_valid, o_rsp_data, o_busy
   );

   modport master (
      output i_req_valid, i_req_op, i_req_a, i_req_b, i_fpu_result,
      input  o_req_ready, o_fpu_alu_op, o_fpu_data_a, o_fpu_data_b,
             o_rsp_valid, o_rsp_data, o_busy
   );
endinterface

// File: rtl/fpu_arb_picker.sv
// Combinational one-hot grant; round-robin from ptr_i with FPU_ARB_ROUND_ROBIN_EN,
// otherwise lowest index wins and ptr_i is ignored.
module fpu_arb_picker
   import fpu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
`ifdef FPU_ARB_ROUND_ROBIN_EN
      // First pass searches ptr..NUM_REQ-1; the plain pass below supplies the wrap.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_o && req_i[i]) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
   end

`ifndef FPU_ARB_ROUND_ROBIN_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one pipelined FPU among NUM_REQ requesters; response 3 cycles after accept, unstallable.
// Ready is the combinational grant; FPU_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module fpu_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_OP  = 1,
   parameter int FPU_LAT = FPU_LAT_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   fpu_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int NSTG  = FPU_LAT + 1;
   localparam int CNT_W = $clog2(FPU_LAT + 2);

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   win;
   logic               xfer;
   logic [IDX_W-1:0]   ptr;

   fpu_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i (bus.i_req_valid),
      .ptr_i (ptr),
      .gnt_o (gnt),
      .idx_o (win),
      .any_o (xfer)
   );

   assign bus.o_req_ready = gnt;

`ifdef FPU_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   logic [NUM_OP-1:0] op_d, op_q;
   logic [31:0]       a_d, a_q, b_d, b_q;

   // Idle cycles issue 0+0 so the FPU never holds stale operands.
   always_comb begin
      op_d = NUM_OP'(OP_ADD);
      a_d  = '0;
      b_d  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            op_d = bus.i_req_op[i*NUM_OP +: NUM_OP];
            a_d  = bus.i_req_a[i*32 +: 32];
            b_d  = bus.i_req_b[i*32 +: 32];
         end
      end
   end

   tag_t [NSTG-1:0] tag_d, tag_q;
   tag_t            tag_last;

   always_comb begin
      tag_d[0].vld = xfer;
      tag_d[0].id  = ID_W'(win);
      for (int k = 1; k < NSTG; k++) tag_d[k] = tag_q[k-1];
   end

   assign tag_last = tag_q[NSTG-1];

   logic [NUM_REQ-1:0] rsp_vld;
   logic               rsp_any;

   always_comb begin
      rsp_vld = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_vld[i] = tag_last.vld && (tag_last.id == ID_W'(i));
      end
   end

   assign rsp_any = |rsp_vld;

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (xfer && !rsp_any)      cnt_d = cnt_q + 1'b1;
      else if (!xfer && rsp_any) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         tag_q <= '0;
         cnt_q <= '0;
      end else begin
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         tag_q <= tag_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.o_fpu_alu_op = op_q;
   assign bus.o_fpu_data_a = a_q;
   assign bus.o_fpu_data_b = b_q;
   assign bus.o_rsp_valid  = rsp_vld;
   assign bus.o_rsp_data   = bus.i_fpu_result;
   assign bus.o_busy       = (cnt_q != '0);

endmodule
